// File: rtl/life_matrix_scan_if.sv
// Frame handshake and LED-matrix drive bundle between the generation
// producer (master) and the matrix scanner (slave).
interface life_matrix_scan_if;
   logic         frame_valid;
   logic [255:0] frame_in;
   logic         frame_ready;
   logic [15:0]  row_sel;
   logic [15:0]  col_data;
   logic         frame_done;
   logic [8:0]   population;

   modport master (
      output frame_valid,
      output frame_in,
      input  frame_ready,
      input  row_sel,
      input  col_data,
      input  frame_done,
      input  population
   );

   modport slave (
      input  frame_valid,
      input  frame_in,
      output frame_ready,
      output row_sel,
      output col_data,
      output frame_done,
      output population
   );
endinterface

// File: rtl/life_matrix_scan.sv
// Latches one 16x16 Game-of-Life generation into a shadow register, counts
// its live cells, then scans it row by row onto a multiplexed LED matrix with
// blanking between rows. New frames are only taken at a frame boundary.
module life_matrix_scan #(
   parameter int ROW_DWELL    = 1024,
   parameter int BLANK_CYCLES = 16
) (
   input  logic               clk,
   input  logic               reset,
   life_matrix_scan_if.slave  bus
);

   localparam int DW = (ROW_DWELL > 1) ? $clog2(ROW_DWELL) : 1;
   localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
   localparam logic [DW-1:0] DWELL_LAST = DW'(ROW_DWELL - 1);
   localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, LOAD, BLANK, SHOW} state_t;

   state_t         state_q, state_d;
   logic [255:0]   shadow_q, shadow_d;
   logic [3:0]     row_q, row_d;
   logic [BW-1:0]  blank_cnt_q, blank_cnt_d;
   logic [DW-1:0]  dwell_cnt_q, dwell_cnt_d;
   logic [8:0]     acc_q, acc_d;
   logic [8:0]     pop_q, pop_d;
   logic [15:0]    row_sel_q, row_sel_d;
   logic [15:0]    col_data_q, col_data_d;
   logic           frame_done_q, frame_done_d;
   logic           frame_ready;
   logic [4:0]     row_pop;
   logic [15:0]    shadow_rows [16];

   // Row r of the grid lives in bits [16r+15:16r] of the shadow word.
   for (genvar gi = 0; gi < 16; gi++) begin : g_rows
      assign shadow_rows[gi] = shadow_q[16*gi +: 16];
   end

   // Ready depends only on registered state; it is held low while in reset.
   assign frame_ready = reset &&
                        ((state_q == IDLE) ||
                         (state_q == SHOW && row_q == 4'd15 && dwell_cnt_q == DWELL_LAST));

   // Live-cell count of the shadow row addressed by row_q (used during LOAD).
   always_comb begin
      row_pop = '0;
      for (int i = 0; i < 16; i++) begin
         row_pop = row_pop + {4'b0, shadow_rows[row_q][i]};
      end
   end

   // Next-state logic: load/count, blank, show, and frame-boundary reload.
   always_comb begin
      state_d      = state_q;
      shadow_d     = shadow_q;
      row_d        = row_q;
      blank_cnt_d  = blank_cnt_q;
      dwell_cnt_d  = dwell_cnt_q;
      acc_d        = acc_q;
      pop_d        = pop_q;
      frame_done_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.frame_valid && frame_ready) begin
               shadow_d = bus.frame_in;
               acc_d    = '0;
               row_d    = '0;
               state_d  = LOAD;
            end
         end
         LOAD: begin
            // row_q doubles as the load index k; it wraps back to row 0.
            acc_d = acc_q + {4'b0, row_pop};
            if (row_q == 4'd15) begin
               pop_d       = acc_q + {4'b0, row_pop};
               row_d       = '0;
               blank_cnt_d = '0;
               state_d     = BLANK;
            end else begin
               row_d = row_q + 4'd1;
            end
         end
         BLANK: begin
            if (blank_cnt_q == BLANK_LAST) begin
               blank_cnt_d = '0;
               dwell_cnt_d = '0;
               state_d     = SHOW;
            end else begin
               blank_cnt_d = blank_cnt_q + BW'(1);
            end
         end
         SHOW: begin
            if (dwell_cnt_q == DWELL_LAST) begin
               dwell_cnt_d = '0;
               blank_cnt_d = '0;
               if (row_q != 4'd15) begin
                  row_d   = row_q + 4'd1;
                  state_d = BLANK;
               end else begin
                  row_d        = '0;
                  frame_done_d = 1'b1;
                  if (bus.frame_valid && frame_ready) begin
                     shadow_d = bus.frame_in;
                     acc_d    = '0;
                     state_d  = LOAD;
                  end else begin
                     state_d = BLANK;
                  end
               end
            end else begin
               dwell_cnt_d = dwell_cnt_q + DW'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      // Drive outputs from the next state so they switch together with it.
      // SHOW is never entered straight from a load, so shadow_q is current.
      row_sel_d  = (state_d == SHOW) ? (16'd1 << row_d) : 16'd0;
      col_data_d = (state_d == SHOW) ? shadow_rows[row_d] : 16'd0;
   end

   // State and output registers; reset blanks the matrix immediately.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         shadow_q     <= '0;
         row_q        <= '0;
         blank_cnt_q  <= '0;
         dwell_cnt_q  <= '0;
         acc_q        <= '0;
         pop_q        <= '0;
         row_sel_q    <= '0;
         col_data_q   <= '0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         shadow_q     <= shadow_d;
         row_q        <= row_d;
         blank_cnt_q  <= blank_cnt_d;
         dwell_cnt_q  <= dwell_cnt_d;
         acc_q        <= acc_d;
         pop_q        <= pop_d;
         row_sel_q    <= row_sel_d;
         col_data_q   <= col_data_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign bus.frame_ready = frame_ready;
   assign bus.row_sel     = row_sel_q;
   assign bus.col_data    = col_data_q;
   assign bus.frame_done  = frame_done_q;
   assign bus.population  = pop_q;

endmodule

// File: tb/tb_life_matrix_scan.sv
// Directed bench for life_matrix_scan with short dwell/blank so a whole
// frame is 96 cycles; every cycle of every frame is compared to the
// expected scan pattern.
module tb_life_matrix_scan;

   localparam int ROW_DWELL    = 4;
   localparam int BLANK_CYCLES = 2;
   localparam int PER_ROW      = ROW_DWELL + BLANK_CYCLES;
   localparam int FRAME        = 16 * PER_ROW;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   life_matrix_scan_if bus();

   life_matrix_scan #(
      .ROW_DWELL    (ROW_DWELL),
      .BLANK_CYCLES (BLANK_CYCLES)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_assert = 0;
   int n_fail   = 0;

   logic [255:0] seed  = 256'h20b541957254c386f5459bda8eac32efa1ce23c28761dea7713acc2fab412b34;
   logic [255:0] ones  = '1;
   logic [255:0] zeros = '0;
   logic [8:0]   pop_seed;

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // The 16 LOAD cycles: blank, not ready, population holds old value.
   task automatic load_phase(input logic [8:0] old_pop, input logic exp_done_first);
      for (int t = 1; t <= 16; t++) begin
         check("load_row_sel", bus.row_sel, 0);
         check("load_col_data", bus.col_data, 0);
         check("load_ready", bus.frame_ready, 0);
         check("load_population", bus.population, old_pop);
         check("load_frame_done", bus.frame_done, (t == 1) ? exp_done_first : 1'b0);
         if (t == 1) bus.frame_valid = 1'b0;
         tick();
      end
   endtask

   // One frame scan starting at BLANK of row 0; ends sampled at the last cycle.
   task automatic scan_frame(input logic [255:0] frame, input logic [8:0] pop,
                             input logic exp_done0, input int valid_at,
                             input logic [255:0] next_frame, input int stop_p);
      for (int p = 0; p < FRAME; p++) begin
         int r;
         int q;
         logic [15:0] exp_sel;
         logic [15:0] exp_col;
         r = p / PER_ROW;
         q = p % PER_ROW;
         if (q < BLANK_CYCLES) begin
            exp_sel = 16'd0;
            exp_col = 16'd0;
         end else begin
            exp_sel = 16'd1 << r;
            exp_col = frame[16*r +: 16];
         end
         check("scan_row_sel", bus.row_sel, exp_sel);
         check("scan_col_data", bus.col_data, exp_col);
         check("scan_population", bus.population, pop);
         check("scan_frame_done", bus.frame_done, (p == 0) ? exp_done0 : 1'b0);
         check("scan_ready", bus.frame_ready, (p == FRAME - 1) ? 1'b1 : 1'b0);
         if (p == valid_at) begin
            bus.frame_valid = 1'b1;
            bus.frame_in    = next_frame;
         end
         if (p == stop_p) break;
         if (p < FRAME - 1) tick();
      end
   endtask

   initial begin
      pop_seed = 9'($countones(seed));
      bus.frame_valid = 1'b1;
      bus.frame_in    = seed;

      // Reset held low with valid asserted: everything quiet.
      repeat (3) begin
         tick();
         check("rst_row_sel", bus.row_sel, 0);
         check("rst_col_data", bus.col_data, 0);
         check("rst_frame_done", bus.frame_done, 0);
         check("rst_population", bus.population, 0);
         check("rst_ready", bus.frame_ready, 0);
      end
      bus.frame_valid = 1'b0;
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("rel_ready", bus.frame_ready, 1);
      check("rel_row_sel", bus.row_sel, 0);
      tick();
      check("idle_ready", bus.frame_ready, 1);

      // Seed load from IDLE.
      bus.frame_valid = 1'b1;
      bus.frame_in    = seed;
      tick();
      load_phase(9'd0, 1'b0);
      scan_frame(seed, pop_seed, 1'b0, -1, zeros, -1);

      // Two repeats without reload.
      tick();
      scan_frame(seed, pop_seed, 1'b1, -1, zeros, -1);
      tick();
      scan_frame(seed, pop_seed, 1'b1, FRAME - 1, ones, -1);

      // All-ones frame; zeros offered mid-row-7, accepted at the boundary.
      tick();
      load_phase(pop_seed, 1'b1);
      scan_frame(ones, 9'd256, 1'b0, 45, zeros, -1);
      tick();
      load_phase(9'd256, 1'b1);

      // Empty frame scans normally, twice.
      scan_frame(zeros, 9'd0, 1'b0, -1, zeros, -1);
      tick();
      scan_frame(zeros, 9'd0, 1'b1, FRAME - 1, seed, -1);

      // Reload the seed and reset during row 9.
      tick();
      load_phase(9'd0, 1'b1);
      scan_frame(seed, pop_seed, 1'b0, -1, zeros, 57);
      #2;
      reset = 1'b0;
      #1;
      check("midrst_row_sel", bus.row_sel, 0);
      check("midrst_col_data", bus.col_data, 0);
      check("midrst_population", bus.population, 0);
      check("midrst_ready", bus.frame_ready, 0);
      check("midrst_frame_done", bus.frame_done, 0);
      tick();
      tick();
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("after_rst_ready", bus.frame_ready, 1);
      check("after_rst_row_sel", bus.row_sel, 0);
      check("after_rst_population", bus.population, 0);
      tick();
      check("after_rst_idle", bus.frame_ready, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
